// File: rtl/loader_pkg.sv
// Shared types and defaults for the CPU program loader.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT_HI,
        WAIT_LO,
        WAIT_DONE,
        FINISH,
        ERROR
    } state_t;

    typedef enum logic {
        ADDR,
        DATA
    } phase_t;

    localparam int DEFAULT_TIMEOUT = 1024;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for single-bit level signals from the CPU clock domain.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Streams a buffered program image into the CPU programming port as
// address/data byte pairs, paced by the CPU ready strobe.
module program_loader
    import loader_pkg::*;
#(
    parameter int RAM_BYTES = 16,
    parameter int ADDR_W    = 4,
    parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              img_we,
    input  logic [ADDR_W-1:0] img_addr,
    input  logic [7:0]        img_data,
    input  logic [ADDR_W:0]   len,
    input  logic              start,
    input  logic              cpu_ready,
    input  logic              cpu_done_load,
    output logic [7:0]        cpu_ui_in,
    output logic              cpu_programming,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam int LEN_W = ADDR_W + 1;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(RAM_BYTES);

    logic [7:0]        image [RAM_BYTES];
    state_t            state;
    phase_t            phase;
    logic [ADDR_W-1:0] k;
    logic [ADDR_W-1:0] last_k;
    logic [CNT_W-1:0]  tmo_cnt;
    logic [LEN_W-1:0]  len_eff;
    logic              tmo_hit;
    logic              rdy_s;
    logic              dn_s;

    function automatic logic [7:0] addr_byte(input logic [ADDR_W-1:0] a);
        return 8'(a);
    endfunction

    sync2 u_sync_rdy (.clk(clk), .rst(rst), .d(cpu_ready),     .q(rdy_s));
    sync2 u_sync_dn  (.clk(clk), .rst(rst), .d(cpu_done_load), .q(dn_s));

    assign len_eff = (len > LEN_MAX) ? LEN_MAX : len;
    assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT - 1));

    // Image survives reset so a board controller can re-run the same load.
    always_ff @(posedge clk) begin
        if (img_we && state == IDLE)
            image[img_addr] <= img_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            phase           <= ADDR;
            k               <= '0;
            last_k          <= '0;
            tmo_cnt         <= '0;
            cpu_ui_in       <= '0;
            cpu_programming <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
        end else begin
            tmo_cnt <= '0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    cpu_ui_in       <= '0;
                    cpu_programming <= 1'b0;
                    busy            <= 1'b0;
                    if (start) begin
                        error  <= 1'b0;
                        busy   <= 1'b1;
                        k      <= '0;
                        phase  <= ADDR;
                        last_k <= ADDR_W'(len_eff - 1'b1);
                        if (len_eff == '0) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            // Outputs are registered, so drive them on entry to ARM.
                            state           <= ARM;
                            cpu_programming <= 1'b1;
                            cpu_ui_in       <= addr_byte('0);
                        end
                    end
                end
                ARM: state <= WAIT_HI;
                WAIT_HI: begin
                    if (tmo_hit) begin
                        state           <= ERROR;
                        error           <= 1'b1;
                        cpu_programming <= 1'b0;
                        cpu_ui_in       <= '0;
                    end else if (rdy_s) begin
                        state <= WAIT_LO;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                WAIT_LO: begin
                    if (tmo_hit) begin
                        state           <= ERROR;
                        error           <= 1'b1;
                        cpu_programming <= 1'b0;
                        cpu_ui_in       <= '0;
                    end else if (!rdy_s) begin
                        if (phase == ADDR) begin
                            phase     <= DATA;
                            cpu_ui_in <= image[k];
                            state     <= WAIT_HI;
                        end else if (k != last_k) begin
                            k         <= k + 1'b1;
                            phase     <= ADDR;
                            cpu_ui_in <= addr_byte(k + 1'b1);
                            state     <= WAIT_HI;
                        end else begin
                            cpu_ui_in <= '0;
                            state     <= WAIT_DONE;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (tmo_hit) begin
                        state           <= ERROR;
                        error           <= 1'b1;
                        cpu_programming <= 1'b0;
                        cpu_ui_in       <= '0;
                    end else if (dn_s) begin
                        state           <= FINISH;
                        done            <= 1'b1;
                        cpu_programming <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                ERROR: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader with a reactive CPU model and a queue-based expected byte stream.
module tb_program_loader;

    localparam int TMO = 1024;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       img_we = 1'b0;
    logic [3:0] img_addr = '0;
    logic [7:0] img_data = '0;
    logic [4:0] len = '0;
    logic       start = 1'b0;
    logic       cpu_ready = 1'b0;
    logic       cpu_done_load = 1'b0;
    logic [7:0] cpu_ui_in;
    logic       cpu_programming;
    logic       busy;
    logic       done;
    logic       error;

    int checks = 0;
    int errors = 0;
    logic [7:0] img_m [16];

    program_loader dut (
        .clk(clk), .rst(rst), .img_we(img_we), .img_addr(img_addr), .img_data(img_data),
        .len(len), .start(start), .cpu_ready(cpu_ready), .cpu_done_load(cpu_done_load),
        .cpu_ui_in(cpu_ui_in), .cpu_programming(cpu_programming), .busy(busy),
        .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic write_img(input int a, input logic [7:0] d);
        img_addr = 4'(a);
        img_data = d;
        img_we   = 1'b1;
        tick();
        img_we   = 1'b0;
        img_m[a] = d;
    endtask

    task automatic pulse_start(input int l);
        len   = 5'(l);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // CPU side of one byte: latch the lane, strobe ready 2 cycles, then idle.
    task automatic cpu_byte(output logic [7:0] b);
        b = cpu_ui_in;
        cpu_ready = 1'b1;
        tick();
        tick();
        chk("hold", 32'(cpu_ui_in), 32'(b));
        cpu_ready = 1'b0;
        repeat (4 + $urandom_range(0, 3)) tick();
    endtask

    task automatic run_load(input int l, input bit disturb);
        logic [7:0] q[$];
        logic [7:0] b;
        int n, ndone;
        bit idle;
        n = (l > 16) ? 16 : l;
        q = {};
        for (int i = 0; i < n; i++) begin
            q.push_back(8'(i));
            q.push_back(img_m[i]);
        end
        pulse_start(l);
        chk("busy_arm", 32'(busy), 1);
        chk("prog_arm", 32'(cpu_programming), 1);
        for (int i = 0; i < q.size(); i++) begin
            cpu_byte(b);
            chk($sformatf("len%0d_byte%0d", l, i), 32'(b), 32'(q[i]));
            if (disturb && i == 0) begin
                img_addr = 4'd1;
                img_data = ~img_m[1];
                img_we   = 1'b1;
                start    = 1'b1;
                len      = 5'd2;
                tick();
                img_we   = 1'b0;
                start    = 1'b0;
            end
            if (l == 20 && i == 30) chk("last_addr", 32'(b), 32'h0F);
        end
        repeat (3) tick();
        chk("ui_post", 32'(cpu_ui_in), 0);
        chk("prog_wait_done", 32'(cpu_programming), 1);
        cpu_done_load = 1'b1;
        ndone = 0;
        idle  = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (done) begin
                ndone++;
                chk("prog_at_done", 32'(cpu_programming), 0);
            end
            if (!busy) begin
                idle = 1'b1;
                break;
            end
        end
        chk("done_cnt", 32'(ndone), 1);
        chk("idle_after", 32'(idle), 1);
        chk("prog_after", 32'(cpu_programming), 0);
        cpu_done_load = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        logic [7:0] b;
        int cyc;

        #2 rst = 1'b1;
        #1;
        chk("rst_ui", 32'(cpu_ui_in), 0);
        chk("rst_prog", 32'(cpu_programming), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(error), 0);
        repeat (2) tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 16; i++) write_img(i, 8'($urandom));
        write_img(0, 8'h1E);
        write_img(1, 8'h2F);
        write_img(2, 8'hE0);
        run_load(3, 1'b0);
        run_load(20, 1'b0);

        for (int r = 0; r < 3; r++) begin
            for (int w = 0; w < 4; w++) write_img($urandom_range(0, 15), 8'($urandom));
            run_load($urandom_range(1, 16), 1'b0);
        end

        run_load(4, 1'b1);

        // CPU never answers: expect timeout error after TMO cycles in WAIT_HI.
        pulse_start(5);
        cyc = 0;
        while (!error && cyc < TMO + 20) begin
            tick();
            cyc++;
        end
        chk("tmo_latency", 32'(cyc), 32'(TMO + 1));
        chk("tmo_err", 32'(error), 1);
        chk("tmo_prog", 32'(cpu_programming), 0);
        chk("tmo_ui", 32'(cpu_ui_in), 0);
        tick();
        chk("tmo_idle", 32'(busy), 0);
        chk("tmo_sticky", 32'(error), 1);

        pulse_start(0);
        chk("len0_done", 32'(done), 1);
        chk("len0_err_clr", 32'(error), 0);
        chk("len0_prog", 32'(cpu_programming), 0);
        chk("len0_ui", 32'(cpu_ui_in), 0);
        tick();
        chk("len0_done_end", 32'(done), 0);
        chk("len0_busy_end", 32'(busy), 0);
        chk("len0_prog_end", 32'(cpu_programming), 0);
        repeat (2) tick();

        // Abort in WAIT_LO of location 5 with an asynchronous reset.
        pulse_start(6);
        for (int i = 0; i < 10; i++) cpu_byte(b);
        chk("abort_addr", 32'(cpu_ui_in), 5);
        cpu_ready = 1'b1;
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        chk("abort_ui", 32'(cpu_ui_in), 0);
        chk("abort_prog", 32'(cpu_programming), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_err", 32'(error), 0);
        tick();
        cpu_ready = 1'b0;
        rst = 1'b0;
        repeat (2) tick();
        run_load(6, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Host-side initiator for the CPU's programming interface. It holds a 16-byte program image written by a test harness or board controller, then drives the CPU's `programming` input and `ui_in` byte lane, streaming one address byte and one data byte per RAM location. Each byte is paced by the CPU's `ready` strobe. Once all bytes are sent, the block waits for `done_load` and then releases programming mode so the CPU can run.

## Interface
- `RAM_BYTES`, 16: image depth; must match the CPU RAM size.
- `ADDR_W`, 4: image address width; clog2(`RAM_BYTES`).
- `TIMEOUT`, 1024: maximum cycles to wait for any CPU handshake edge before flagging an error.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `img_we` in 1: write strobe into the image buffer.
- `img_addr` in `ADDR_W`: image write address.
- `img_data` in 8: image write data.
- `len` in `ADDR_W`+1: number of locations to load. 0 means load nothing; values above `RAM_BYTES` clamp to `RAM_BYTES`.
- `start` in 1: single-cycle request to begin a load. Sampled only in IDLE.
- `cpu_ready` in 1: CPU `ready` output (uio_out[1]). Asynchronous to our logic.
- `cpu_done_load` in 1: CPU `done_load` output (uio_out[2]). Asynchronous to our logic.
- `cpu_ui_in` out 8: byte driven to the CPU `ui_in`.
- `cpu_programming` out 1: driven to CPU uio_in[0].
- `busy` out 1: high from the cycle after `start` is accepted until return to IDLE.
- `done` out 1: one-cycle pulse on successful completion.
- `error` out 1: sticky. Cleared only by `rst` or by the next accepted `start`.

## Operation
- `cpu_ready` and `cpu_done_load` each pass through a 2-flop synchronizer. All FSM decisions use the synchronized versions `rdy_s` and `dn_s`.
- Byte sequence for location k (0..len-1):
  - Address byte {(8-`ADDR_W`)'b0, k}.
  - Then data byte `image[k]`.
- State machine:
  - IDLE: all outputs low.
    - `start` with effective len = 0: go to FINISH.
    - `start` with effective len > 0: go to ARM. Load byte index 0 and phase ADDR.
  - ARM: assert `cpu_programming`, place the address byte for k=0 on `cpu_ui_in`, go to WAIT_HI.
  - WAIT_HI: hold `cpu_ui_in`. When `rdy_s`=1, go to WAIT_LO.
  - WAIT_LO: hold `cpu_ui_in`. When `rdy_s`=0, the byte is consumed:
    - Phase ADDR: switch to DATA, present `image[k]`, go to WAIT_HI.
    - Phase DATA, not last location: k++, switch to ADDR, present the next address byte, go to WAIT_HI.
    - Phase DATA, last location: go to WAIT_DONE.
  - WAIT_DONE: `cpu_ui_in` = 0. When `dn_s`=1, go to FINISH.
  - FINISH: deassert `cpu_programming`, pulse `done`, go to IDLE.
  - ERROR: set `error`, deassert `cpu_programming`, `cpu_ui_in` = 0, go to IDLE.
- Timeout counter:
  - Clears on every state change.
  - Increments while in WAIT_HI, WAIT_LO or WAIT_DONE.
  - Reaching `TIMEOUT`-1 forces ERROR.
- `img_we` is honoured in IDLE only and ignored while `busy`. The image is never cleared by reset.
- `start` while `busy` is ignored.
- `rst` mid-load: every output goes to 0 immediately and asynchronously, including `cpu_programming`, which aborts the CPU's load. The FSM returns to IDLE.

## Timing
- Reset values: `cpu_ui_in`=0, `cpu_programming`=0, `busy`=0, `done`=0, `error`=0. FSM in IDLE, k=0, phase ADDR.
- `start` at cycle 0: `busy` and `cpu_programming` high at cycle 1 (ARM). The first address byte is stable at cycle 1.
- Handshake latency: 2 synchronizer cycles plus 1 FSM cycle from a raw `cpu_ready` edge to the state change. The next byte appears on `cpu_ui_in` 3 cycles after raw `cpu_ready` falls.
- `cpu_ui_in` changes only on state transitions, never while `rdy_s`=1.
- Minimum load time is `len`×2 handshakes plus the `done_load` wait.
- `done` pulses in the FINISH cycle. `busy` is low in the following cycle.

## Structure
- Shared package `loader_pkg`:
  - State enum (IDLE, ARM, WAIT_HI, WAIT_LO, WAIT_DONE, FINISH, ERROR).
  - Phase enum (ADDR, DATA).
  - Default `TIMEOUT` constant.
- Sub-module `sync2`: 2-flop synchronizer with async active-high reset to 0. Instantiated twice, once each for `cpu_ready` and `cpu_done_load`.
- The image is a flop array inside `program_loader`.

## Test plan
- Write image[0..2] = 0x1E, 0x2F, 0xE0; `len`=3; a CPU model pulses `ready` 2 cycles high per byte. Required: `cpu_ui_in` sequence 0x00, 0x1E, 0x01, 0x2F, 0x02, 0xE0. After the model raises `done_load`: `done` pulses once, then `cpu_programming`=0.
- `len`=0 with `start`: `done` pulses at cycle 1. `cpu_programming` never rises and `cpu_ui_in` stays 0.
- `len`=20: exactly 16 locations (32 bytes) are sent. The last address byte is 0x0F.
- CPU model never asserts `ready`: `error`=1 after `TIMEOUT` cycles in WAIT_HI, `cpu_programming`=0, back in IDLE. A new `start` clears `error`.
- `rst` pulse while in WAIT_LO of location 5: all outputs 0 asynchronously. After reset, `start` with `len`=6 restarts from address 0x00.
- `img_we` and `start` issued while `busy`: the image contents and the ongoing sequence are unchanged.
